mem_lsu: RTL and testbench

- MEM-stage load/store unit; consumes the EX/MEM pipeline register outputs (address, store data, func3, mem_read/mem_write).
- Drives a req/gnt/rvalid data-memory port and stalls the pipeline until the access completes.
- Returns the aligned, sign- or zero-extended load result to the MEM/WB register.

---
 rtl/core_lsu_pkg.sv | 44 ++++
 rtl/mem_lsu_load_align.sv | 27 ++
 rtl/mem_lsu.sv | 164 ++++++++++++++++
 tb/tb_mem_lsu.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_lsu_pkg.sv
// rtl/core_lsu_pkg.sv - shared func3 codes, FSM states and size/offset helpers for the MEM-stage LSU
package core_lsu_pkg;

   localparam logic [2:0] F3_B   = 3'b000;
   localparam logic [2:0] F3_H   = 3'b001;
   localparam logic [2:0] F3_W   = 3'b010;
   localparam logic [2:0] F3_BU  = 3'b100;
   localparam logic [2:0] F3_HU  = 3'b101;

   localparam logic [3:0] BE_ALL = 4'b1111;

   typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} lsu_state_e;

   typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} lsu_size_e;

   // Unlisted codes (011, 110, 111) fall through to word accesses.
   function automatic lsu_size_e f3_size(input logic [2:0] f3);
      case (f3)
         F3_B, F3_BU: return SZ_B;
         F3_H, F3_HU: return SZ_H;
         F3_W:        return SZ_W;
         default:     return SZ_W;
      endcase
   endfunction

   // Byte offset actually used for lane selection: halfwords only look at
   // addr[1], words at nothing, so stray low bits never move the data.
   function automatic logic [1:0] eff_off(input logic [2:0] f3, input logic [1:0] a);
      case (f3_size(f3))
         SZ_B:    return a;
         SZ_H:    return {a[1], 1'b0};
         default: return 2'b00;
      endcase
   endfunction

   function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] a);
      case (f3_size(f3))
         SZ_H:    return a[0];
         SZ_W:    return |a;
         default: return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/mem_lsu_load_align.sv
// rtl/mem_lsu_load_align.sv - combinational lane extract and sign/zero extension of a load word
module mem_lsu_load_align
   import core_lsu_pkg::*;
(
   input  logic [31:0] rdata_i,
   input  logic [1:0]  off_i,
   input  logic [2:0]  func3_i,
   output logic [31:0] result_o
);

   logic [31:0] shifted;

   assign shifted = rdata_i >> {off_i, 3'b000};

   // Pick the addressed lane from the shifted word and extend it to 32 bits.
   always_comb begin
      result_o = shifted;
      case (func3_i)
         F3_B:    result_o = {{24{shifted[7]}}, shifted[7:0]};
         F3_BU:   result_o = {24'h000000, shifted[7:0]};
         F3_H:    result_o = {{16{shifted[15]}}, shifted[15:0]};
         F3_HU:   result_o = {16'h0000, shifted[15:0]};
         default: result_o = shifted;
      endcase
   end

endmodule

// File: rtl/mem_lsu.sv
// rtl/mem_lsu.sv - MEM-stage load/store unit on a req/gnt/rvalid port; MEM_LSU_MISALIGN_TRAP_EN enables misalign trapping
module mem_lsu
   import core_lsu_pkg::*;
#(
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [31:0]       me_alu_o,
   input  logic [31:0]       me_regs_data2,
   input  logic [2:0]        me_func3_code,
   input  logic              me_mem_read,
   input  logic              me_mem_write,
   output logic              dmem_req,
   output logic              dmem_we,
   output logic [ADDR_W-1:0] dmem_addr,
   output logic [3:0]        dmem_be,
   output logic [31:0]       dmem_wdata,
   input  logic              dmem_gnt,
   input  logic              dmem_rvalid,
   input  logic [31:0]       dmem_rdata,
   output logic              lsu_stall,
   output logic [31:0]       lsu_rdata,
   output logic              lsu_done,
   output logic              lsu_misalign
);

   lsu_state_e        state_q, state_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [3:0]        be_q, be_d;
   logic [31:0]       wdata_q, wdata_d;
   logic [1:0]        off_q, off_d;
   logic [2:0]        f3_q, f3_d;
   logic [31:0]       rdata_q, rdata_d;
   logic              misalign_q, misalign_d;

   logic              op;
   logic              misalign;
   logic [1:0]        in_off;
   logic [3:0]        in_be;
   logic [31:0]       in_wdata;
   logic [31:0]       load_res;

   assign op     = me_mem_read | me_mem_write;
   assign in_off = eff_off(me_func3_code, me_alu_o[1:0]);

`ifdef MEM_LSU_MISALIGN_TRAP_EN
   assign misalign = op & is_misaligned(me_func3_code, me_alu_o[1:0]);
`else
   assign misalign = 1'b0;
`endif

   // Lane enables and replicated store data for the incoming access.
   always_comb begin
      in_be    = BE_ALL;
      in_wdata = me_regs_data2;
      case (f3_size(me_func3_code))
         SZ_B: begin
            in_be    = 4'b0001 << in_off;
            in_wdata = {4{me_regs_data2[7:0]}};
         end
         SZ_H: begin
            in_be    = 4'b0011 << in_off;
            in_wdata = {2{me_regs_data2[15:0]}};
         end
         default: begin
            in_be    = BE_ALL;
            in_wdata = me_regs_data2;
         end
      endcase
   end

   mem_lsu_load_align u_load_align (
      .rdata_i  (dmem_rdata),
      .off_i    (off_q),
      .func3_i  (f3_q),
      .result_o (load_res)
   );

   // Next-state and payload capture; payload is frozen from IDLE until the grant.
   always_comb begin
      state_d    = state_q;
      we_d       = we_q;
      addr_d     = addr_q;
      be_d       = be_q;
      wdata_d    = wdata_q;
      off_d      = off_q;
      f3_d       = f3_q;
      rdata_d    = rdata_q;
      misalign_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (op) begin
               if (misalign) begin
                  misalign_d = 1'b1;
                  state_d    = DONE;
               end else begin
                  we_d    = me_mem_write & ~me_mem_read;
                  addr_d  = {me_alu_o[ADDR_W-1:2], 2'b00};
                  be_d    = in_be;
                  wdata_d = in_wdata;
                  off_d   = in_off;
                  f3_d    = me_func3_code;
                  state_d = REQ;
               end
            end
         end
         REQ: begin
            if (dmem_gnt) begin
               state_d = we_q ? DONE : WAIT;
            end
         end
         WAIT: begin
            if (dmem_rvalid) begin
               rdata_d = load_res;
               state_d = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and payload registers; reset clears every visible output.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         we_q       <= 1'b0;
         addr_q     <= '0;
         be_q       <= 4'b0000;
         wdata_q    <= 32'h0;
         off_q      <= 2'b00;
         f3_q       <= 3'b000;
         rdata_q    <= 32'h0;
         misalign_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         we_q       <= we_d;
         addr_q     <= addr_d;
         be_q       <= be_d;
         wdata_q    <= wdata_d;
         off_q      <= off_d;
         f3_q       <= f3_d;
         rdata_q    <= rdata_d;
         misalign_q <= misalign_d;
      end
   end

   assign dmem_req     = (state_q == REQ);
   assign dmem_we      = we_q;
   assign dmem_addr    = addr_q;
   assign dmem_be      = be_q;
   assign dmem_wdata   = wdata_q;
   assign lsu_rdata    = rdata_q;
   assign lsu_done     = (state_q == DONE);
   assign lsu_misalign = misalign_q;
   assign lsu_stall    = ((state_q == IDLE) & op & ~misalign) | (state_q == REQ) | (state_q == WAIT);

endmodule

// File: tb/tb_mem_lsu.sv
// tb/tb_mem_lsu.sv - directed scoreboard bench for mem_lsu
module tb_mem_lsu;

   typedef struct packed {
      logic        we;
      logic [31:0] addr;
      logic [3:0]  be;
      logic [31:0] wdata;
   } req_t;

   logic        clk;
   logic        rst;
   logic [31:0] me_alu_o;
   logic [31:0] me_regs_data2;
   logic [2:0]  me_func3_code;
   logic        me_mem_read;
   logic        me_mem_write;
   logic        dmem_req;
   logic        dmem_we;
   logic [31:0] dmem_addr;
   logic [3:0]  dmem_be;
   logic [31:0] dmem_wdata;
   logic        dmem_gnt;
   logic        dmem_rvalid;
   logic [31:0] dmem_rdata;
   logic        lsu_stall;
   logic [31:0] lsu_rdata;
   logic        lsu_done;
   logic        lsu_misalign;

   int          checks;
   int          errors;
   req_t        exp_req_q[$];
   logic [31:0] exp_rdata_q[$];

   mem_lsu #(.ADDR_W(32)) dut (
      .clk           (clk),
      .rst           (rst),
      .me_alu_o      (me_alu_o),
      .me_regs_data2 (me_regs_data2),
      .me_func3_code (me_func3_code),
      .me_mem_read   (me_mem_read),
      .me_mem_write  (me_mem_write),
      .dmem_req      (dmem_req),
      .dmem_we       (dmem_we),
      .dmem_addr     (dmem_addr),
      .dmem_be       (dmem_be),
      .dmem_wdata    (dmem_wdata),
      .dmem_gnt      (dmem_gnt),
      .dmem_rvalid   (dmem_rvalid),
      .dmem_rdata    (dmem_rdata),
      .lsu_stall     (lsu_stall),
      .lsu_rdata     (lsu_rdata),
      .lsu_done      (lsu_done),
      .lsu_misalign  (lsu_misalign)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] model_load(input logic [31:0] w, input logic [1:0] a, input logic [2:0] f3);
      logic [7:0]  b;
      logic [15:0] h;
      b = (a == 2'd0) ? w[7:0] : (a == 2'd1) ? w[15:8] : (a == 2'd2) ? w[23:16] : w[31:24];
      h = a[1] ? w[31:16] : w[15:0];
      case (f3)
         3'b000:  return {{24{b[7]}}, b};
         3'b100:  return {24'h0, b};
         3'b001:  return {{16{h[15]}}, h};
         3'b101:  return {16'h0, h};
         default: return w;
      endcase
   endfunction

   function automatic logic [3:0] model_be(input logic [2:0] f3, input logic [1:0] a);
      case (f3)
         3'b000, 3'b100: return (a == 2'd0) ? 4'b0001 : (a == 2'd1) ? 4'b0010 : (a == 2'd2) ? 4'b0100 : 4'b1000;
         3'b001, 3'b101: return a[1] ? 4'b1100 : 4'b0011;
         default:        return 4'b1111;
      endcase
   endfunction

   task automatic drive_op(input logic rd, input logic wr, input logic [31:0] addr,
                           input logic [31:0] data, input logic [2:0] f3);
      me_alu_o      = addr;
      me_regs_data2 = data;
      me_func3_code = f3;
      me_mem_read   = rd;
      me_mem_write  = wr;
   endtask

   task automatic run_access(input logic rd, input logic wr, input logic [31:0] addr,
                             input logic [31:0] data, input logic [2:0] f3,
                             input int gdly, input int rdly, input logic [31:0] rword);
      req_t        cur;
      logic [31:0] exp_r;
      int          dones;
      dones = 0;
      exp_r = 32'h0;
      drive_op(rd, wr, addr, data, f3);
      #1;
      chk("c0_stall", lsu_stall, 1);
      chk("c0_req", dmem_req, 0);
      tick();
      cur = exp_req_q.pop_front();
      for (int i = 0; i <= gdly; i++) begin
         chk("req_hi", dmem_req, 1);
         chk("req_stall", lsu_stall, 1);
         chk("req_we", dmem_we, cur.we);
         chk("req_addr", dmem_addr, cur.addr);
         chk("req_be", dmem_be, cur.be);
         if (cur.we) chk("req_wdata", dmem_wdata, cur.wdata);
         dones += lsu_done;
         if (i == gdly) dmem_gnt = 1'b1;
         tick();
         dmem_gnt = 1'b0;
      end
      if (rd) begin
         for (int j = 0; j <= rdly; j++) begin
            chk("wait_noreq", dmem_req, 0);
            chk("wait_stall", lsu_stall, 1);
            dones += lsu_done;
            if (j == rdly) begin
               dmem_rvalid = 1'b1;
               dmem_rdata  = rword;
            end
            tick();
            dmem_rvalid = 1'b0;
            dmem_rdata  = 32'h5A5A5A5A;
         end
      end
      chk("done_hi", lsu_done, 1);
      chk("done_stall", lsu_stall, 0);
      chk("done_noreq", dmem_req, 0);
      dones += lsu_done;
      if (rd) begin
         exp_r = exp_rdata_q.pop_front();
         chk("load_rdata", lsu_rdata, exp_r);
      end
      drive_op(1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
      tick();
      dones += lsu_done;
      chk("done_count", dones, 1);
      chk("idle_stall", lsu_stall, 0);
      chk("idle_noreq", dmem_req, 0);
      if (rd) chk("rdata_hold", lsu_rdata, exp_r);
   endtask

   initial begin
      logic [31:0] w;
      logic [31:0] a;
      logic [31:0] prev;
      checks        = 0;
      errors        = 0;
      rst           = 1'b0;
      dmem_gnt      = 1'b0;
      dmem_rvalid   = 1'b0;
      dmem_rdata    = 32'h5A5A5A5A;
      drive_op(1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
      #2 rst = 1'b1;
      tick();
      chk("rst_req", dmem_req, 0);
      chk("rst_we", dmem_we, 0);
      chk("rst_addr", dmem_addr, 0);
      chk("rst_be", dmem_be, 0);
      chk("rst_wdata", dmem_wdata, 0);
      chk("rst_rdata", lsu_rdata, 0);
      chk("rst_done", lsu_done, 0);
      chk("rst_misalign", lsu_misalign, 0);
      chk("rst_stall", lsu_stall, 0);
      rst = 1'b0;
      tick();

      // SW with immediate grant
      exp_req_q.push_back('{1'b1, 32'h100, 4'b1111, 32'hDEADBEEF});
      run_access(1'b0, 1'b1, 32'h100, 32'hDEADBEEF, 3'b010, 0, 0, 32'h0);

      // LB / LBU / LHU extraction
      exp_req_q.push_back('{1'b0, 32'h200, 4'b1000, 32'h0});
      exp_rdata_q.push_back(32'hFFFFFF80);
      run_access(1'b1, 1'b0, 32'h203, 32'h0, 3'b000, 0, 0, 32'h80FFFF7F);
      exp_req_q.push_back('{1'b0, 32'h200, 4'b1000, 32'h0});
      exp_rdata_q.push_back(32'h00000080);
      run_access(1'b1, 1'b0, 32'h203, 32'h0, 3'b100, 0, 0, 32'h80FFFF7F);
      exp_req_q.push_back('{1'b0, 32'h200, 4'b1100, 32'h0});
      exp_rdata_q.push_back(32'h000080FF);
      run_access(1'b1, 1'b0, 32'h202, 32'h0, 3'b101, 0, 0, 32'h80FFFF7F);

      // SH to the upper half
      exp_req_q.push_back('{1'b1, 32'h04, 4'b1100, 32'hABCDABCD});
      run_access(1'b0, 1'b1, 32'h06, 32'h1234ABCD, 3'b001, 0, 0, 32'h0);

      // SB lane replication
      exp_req_q.push_back('{1'b1, 32'h08, 4'b0010, 32'h5E5E5E5E});
      run_access(1'b0, 1'b1, 32'h09, 32'h0000005E, 3'b000, 0, 0, 32'h0);

      // LW with delayed grant and response
      exp_req_q.push_back('{1'b0, 32'h340, 4'b1111, 32'h0});
      exp_rdata_q.push_back(32'h13579BDF);
      run_access(1'b1, 1'b0, 32'h340, 32'h0, 3'b010, 3, 2, 32'h13579BDF);

      // Read wins when both read and write are asserted
      exp_req_q.push_back('{1'b0, 32'h800, 4'b1111, 32'h0});
      exp_rdata_q.push_back(32'hCAFEF00D);
      run_access(1'b1, 1'b1, 32'h800, 32'h77777777, 3'b010, 1, 0, 32'hCAFEF00D);

      // Byte and halfword loads across lanes with random words
      for (int k = 0; k < 4; k++) begin
         w = $urandom;
         a = 32'h400 + k;
         exp_req_q.push_back('{1'b0, 32'h400, model_be(3'b000, a[1:0]), 32'h0});
         exp_rdata_q.push_back(model_load(w, a[1:0], 3'b000));
         run_access(1'b1, 1'b0, a, 32'h0, 3'b000, 0, k, w);
         w = $urandom;
         a = 32'h500 + 2 * (k % 2);
         exp_req_q.push_back('{1'b0, 32'h500, model_be(3'b001, a[1:0]), 32'h0});
         exp_rdata_q.push_back(model_load(w, a[1:0], 3'b001));
         run_access(1'b1, 1'b0, a, 32'h0, 3'b001, k, 0, w);
      end

      // Reset while waiting for read data, then a stale response
      exp_req_q.push_back('{1'b0, 32'h600, 4'b1111, 32'h0});
      drive_op(1'b1, 1'b0, 32'h600, 32'h0, 3'b010);
      tick();
      chk("abort_req", dmem_req, 1);
      void'(exp_req_q.pop_front());
      dmem_gnt = 1'b1;
      tick();
      dmem_gnt = 1'b0;
      chk("abort_wait_stall", lsu_stall, 1);
      #2;
      rst = 1'b1;
      drive_op(1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
      #1;
      chk("arst_req", dmem_req, 0);
      chk("arst_addr", dmem_addr, 0);
      chk("arst_be", dmem_be, 0);
      chk("arst_rdata", lsu_rdata, 0);
      chk("arst_done", lsu_done, 0);
      chk("arst_stall", lsu_stall, 0);
      tick();
      rst = 1'b0;
      dmem_rvalid = 1'b1;
      dmem_rdata  = 32'hDEAD0000;
      tick();
      dmem_rvalid = 1'b0;
      dmem_gnt    = 1'b1;
      chk("stale_rdata", lsu_rdata, 0);
      chk("stale_done", lsu_done, 0);
      tick();
      dmem_gnt = 1'b0;
      chk("stray_gnt_req", dmem_req, 0);
      chk("stray_gnt_done", lsu_done, 0);

      // FSM usable again after the abort
      exp_req_q.push_back('{1'b0, 32'h700, 4'b0001, 32'h0});
      exp_rdata_q.push_back(32'h0000007F);
      run_access(1'b1, 1'b0, 32'h700, 32'h0, 3'b000, 0, 0, 32'h1234567F);

      // Misaligned word load
`ifdef MEM_LSU_MISALIGN_TRAP_EN
      prev = lsu_rdata;
      drive_op(1'b1, 1'b0, 32'h101, 32'h0, 3'b010);
      #1;
      chk("mis_c0_stall", lsu_stall, 0);
      chk("mis_c0_req", dmem_req, 0);
      tick();
      drive_op(1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
      chk("mis_pulse", lsu_misalign, 1);
      chk("mis_noreq", dmem_req, 0);
      tick();
      chk("mis_pulse_end", lsu_misalign, 0);
      chk("mis_noreq2", dmem_req, 0);
      chk("mis_rdata", lsu_rdata, prev);
`else
      prev = 32'h89ABCDEF;
      exp_req_q.push_back('{1'b0, 32'h100, 4'b1111, 32'h0});
      exp_rdata_q.push_back(model_load(prev, 2'b01, 3'b010));
      run_access(1'b1, 1'b0, 32'h101, 32'h0, 3'b010, 0, 0, prev);
      chk("no_misalign", lsu_misalign, 0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
